mant_seq_divider: RTL and testbench

//  Iterative radix-2 restoring divider for unsigned mantissas. It is the inverse datapath of the
//  FPU multiplier and sits beside it in the divide path of the FPU.

---
 rtl/mant_seq_divider.sv | 112 +++++++++++
 tb/tb_mant_seq_divider.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mant_seq_divider.sv
// Radix-2 restoring divider for unsigned N-bit mantissas: Q = A / B, R = A % B.
// One quotient bit per cycle from a single (N+1)-bit subtractor, valid/ready on both sides.
module mant_seq_divider #(
    parameter int N = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         div_by_zero
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  dvs_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  q_q, r_q;
    logic          dbz_q;
    logic [N:0]    t;
    logic          last;

    // rem < dvs always holds, so the (N+1)-bit difference lies in (-2^N, 2^N) and its MSB is the sign.
    assign t    = {rem_q, quo_q[N-1]} - {1'b0, dvs_q};
    assign last = (cnt_q == CW'(N - 1));

    always_comb begin
        if (t[N]) begin
            rem_d = {rem_q[N-2:0], quo_q[N-1]};
            quo_d = {quo_q[N-2:0], 1'b0};
        end else begin
            rem_d = t[N-1:0];
            quo_d = {quo_q[N-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = (B == '0) ? DONE : CALC;
            CALC:    if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
    end

    // Result registers are separate from the working registers so outputs hold through CALC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            q_q   <= '0;
            r_q   <= '0;
            dbz_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (B == '0) begin
                            q_q   <= '1;
                            r_q   <= A;
                            dbz_q <= 1'b1;
                        end else begin
                            rem_q <= '0;
                            quo_q <= A;
                            dvs_q <= B;
                            cnt_q <= '0;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        q_q   <= quo_d;
                        r_q   <= rem_d;
                        dbz_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Q           = q_q;
    assign R           = r_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mant_seq_divider.sv
// Bench for mant_seq_divider: directed N=8 cases with literal expectations, plus a
// randomized N=24 run scored against plain A/B, A%B arithmetic and a cycle-level latency model.
module tb_mant_seq_divider;

    localparam int N24  = 24;
    localparam int NOPS = 1200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // N = 8 instance
    logic       rst8 = 1'b1, in_valid8 = 1'b0, out_ready8 = 1'b0;
    logic [7:0] A8 = '0, B8 = '0;
    logic       in_ready8, out_valid8, dbz8;
    logic [7:0] Q8, R8;

    // N = 24 instance
    logic           rst24 = 1'b1, in_valid24 = 1'b0, out_ready24 = 1'b0;
    logic [N24-1:0] A24 = '0, B24 = '0;
    logic           in_ready24, out_valid24, dbz24;
    logic [N24-1:0] Q24, R24;

    mant_seq_divider #(.N(8)) u8 (
        .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(A8), .B(B8), .out_valid(out_valid8), .out_ready(out_ready8),
        .Q(Q8), .R(R8), .div_by_zero(dbz8)
    );

    mant_seq_divider #(.N(N24)) u24 (
        .clk(clk), .rst(rst24), .in_valid(in_valid24), .in_ready(in_ready24),
        .A(A24), .B(B24), .out_valid(out_valid24), .out_ready(out_ready24),
        .Q(Q24), .R(R24), .div_by_zero(dbz24)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Latency is counted in cycles from the negedge where the operands are presented.
    task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input int hold, input bit junk,
                       input logic [7:0] eq, input logic [7:0] er, input bit ed, input int elat);
        int k;
        k = 0;
        while (!in_ready8 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({nm, " in_ready"}, 32'(in_ready8), 32'd1);
        in_valid8 = 1'b1;
        A8 = a;
        B8 = b;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            in_valid8 = junk ? 1'($urandom % 2) : 1'b0;
            A8 = 8'($urandom);
            B8 = 8'($urandom);
        end while (!out_valid8 && k < 40);
        check({nm, " latency"}, 32'(k), 32'(elat));
        check({nm, " Q"}, 32'(Q8), 32'(eq));
        check({nm, " R"}, 32'(R8), 32'(er));
        check({nm, " dbz"}, 32'(dbz8), 32'(ed));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid8 = junk ? 1'($urandom % 2) : 1'b0;
            check({nm, " hold out_valid"}, 32'(out_valid8), 32'd1);
            check({nm, " hold in_ready"}, 32'(in_ready8), 32'd0);
            check({nm, " hold Q"}, 32'(Q8), 32'(eq));
            check({nm, " hold R"}, 32'(R8), 32'(er));
        end
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        check({nm, " drop out_valid"}, 32'(out_valid8), 32'd0);
        check({nm, " idle in_ready"}, 32'(in_ready8), 32'd1);
        check({nm, " idle Q"}, 32'(Q8), 32'(eq));
    endtask

    task automatic directed8();
        int k;
        repeat (2) @(negedge clk);
        check("rst in_ready", 32'(in_ready8), 32'd0);
        check("rst out_valid", 32'(out_valid8), 32'd0);
        check("rst Q", 32'(Q8), 32'd0);
        check("rst R", 32'(R8), 32'd0);
        check("rst dbz", 32'(dbz8), 32'd0);
        rst8 = 1'b0;
        @(negedge clk);
        check("post-rst in_ready", 32'(in_ready8), 32'd1);

        op8("t1 100/7",  8'd100, 8'd7,   0, 1'b0, 8'd14,  8'd2,  1'b0, 9);
        op8("t2 255/1",  8'd255, 8'd1,   0, 1'b0, 8'd255, 8'd0,  1'b0, 9);
        op8("t2 3/200",  8'd3,   8'd200, 0, 1'b0, 8'd0,   8'd3,  1'b0, 9);
        op8("t2 0/9",    8'd0,   8'd9,   0, 1'b0, 8'd0,   8'd0,  1'b0, 9);
        op8("t3 5/0",    8'd5,   8'd0,   0, 1'b0, 8'hFF,  8'd5,  1'b1, 1);
        op8("t3 9/3",    8'd9,   8'd3,   0, 1'b0, 8'd3,   8'd0,  1'b0, 9);
        op8("t4 200/13", 8'd200, 8'd13,  5, 1'b1, 8'd15,  8'd5,  1'b0, 9);

        // Abort in the 4th CALC cycle of 77/4.
        k = 0;
        while (!in_ready8 && k < 40) begin
            @(negedge clk);
            k++;
        end
        in_valid8 = 1'b1;
        A8 = 8'd77;
        B8 = 8'd4;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        check("t5 pre-rst Q", 32'(Q8), 32'd15);
        rst8 = 1'b1;
        #1;
        check("t5 rst out_valid", 32'(out_valid8), 32'd0);
        check("t5 rst Q", 32'(Q8), 32'd0);
        check("t5 rst R", 32'(R8), 32'd0);
        check("t5 rst in_ready", 32'(in_ready8), 32'd0);
        @(negedge clk);
        rst8 = 1'b0;
        @(negedge clk);
        check("t5 release in_ready", 32'(in_ready8), 32'd1);
        check("t5 release out_valid", 32'(out_valid8), 32'd0);
        op8("t5 77/4", 8'd77, 8'd4, 0, 1'b0, 8'd19, 8'd1, 1'b0, 9);
    endtask

    // Reference model for the N=24 instance: issue-order queue with due cycles.
    typedef struct {
        logic [N24-1:0] a;
        logic [N24-1:0] b;
        int             due;
    } op_t;

    op_t            sb[$];
    int             acc24 = 0;
    int             done24 = 0;
    bit             have_last = 1'b0;
    logic [N24-1:0] last_q = '0, last_r = '0;

    always @(negedge clk) begin : cmp24
        bit             exp_ov;
        logic [N24-1:0] eq, er;
        if (!rst24) begin
            exp_ov = (sb.size() > 0) && (cyc >= sb[0].due);
            check("r24 out_valid", 32'(out_valid24), 32'(exp_ov));
            check("r24 in_ready", 32'(in_ready24), 32'(sb.size() == 0));
            if (exp_ov && out_valid24) begin
                if (sb[0].b == '0) begin
                    eq = '1;
                    er = sb[0].a;
                end else begin
                    eq = sb[0].a / sb[0].b;
                    er = sb[0].a % sb[0].b;
                end
                check("r24 Q", 32'(Q24), 32'(eq));
                check("r24 R", 32'(R24), 32'(er));
                check("r24 dbz", 32'(dbz24), 32'(sb[0].b == '0));
                if (out_ready24) begin
                    last_q    = eq;
                    last_r    = er;
                    have_last = 1'b1;
                    void'(sb.pop_front());
                    done24++;
                end
            end else if (have_last) begin
                check("r24 held Q", 32'(Q24), 32'(last_q));
                check("r24 held R", 32'(R24), 32'(last_r));
            end
            if (in_valid24 && in_ready24) begin
                sb.push_back('{a: A24, b: B24, due: cyc + ((B24 == '0) ? 1 : N24 + 1)});
                acc24++;
            end
        end
    end

    task automatic random24();
        int k;
        repeat (3) @(negedge clk);
        rst24 = 1'b0;
        while (acc24 < NOPS && cyc < 80000) begin
            @(posedge clk);
            #1;
            in_valid24  = ($urandom % 3) != 0;
            out_ready24 = 1'($urandom % 2);
            A24 = (($urandom % 8) == 0) ? '0 : N24'($urandom);
            case ($urandom % 8)
                0:       B24 = '0;
                1:       B24 = 24'd1;
                2:       B24 = N24'($urandom_range(2, 255));
                3:       B24 = N24'($urandom) | 24'h800000;
                default: B24 = N24'($urandom);
            endcase
        end
        in_valid24  = 1'b0;
        out_ready24 = 1'b1;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check("r24 drained", 32'(sb.size()), 32'd0);
        check("r24 issued vs retired", 32'(done24), 32'(acc24));
        check("r24 op count reached", 32'(acc24 >= NOPS), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            directed8();
            random24();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
